conway_scan_control: RTL and testbench

CONWAY_SCAN_CONTROL -- requirements
Module: conway_scan_control

---
 rtl/conway_scan_control.sv | 160 ++++++++++++++++
 tb/tb_conway_scan_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_scan_control.sv
// Scan sequencer for a banked Game-of-Life engine.
// Walks every pixel of a grid of 3x3 blocks, one pixel per unstalled cycle. The grid is stored
// across nine banks, one per position inside a block. For each pixel it drives the write
// enable and address of the centre bank, and the read enables and addresses of the nine
// banks that hold its 3x3 neighbourhood.
module conway_scan_control #(
  parameter int unsigned WIDTH_BLOCKS  = 2,
  parameter int unsigned HEIGHT_BLOCKS = 2,
  parameter int unsigned ADDR_WIDTH    = 2,
  parameter int unsigned WRAP_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [15:0]             generations,
  input  logic                    stop,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [8:0]              write_enable,
  output logic [8:0]              read_enable,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [9*ADDR_WIDTH-1:0] read_addr,
  output logic                    frame_buffer_select,
  output logic [15:0]             generation_count
);

  localparam int unsigned BxW = $clog2(WIDTH_BLOCKS);
  localparam int unsigned ByW = $clog2(HEIGHT_BLOCKS);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e         state_q;
  logic [1:0]     px_q, py_q;
  logic [BxW-1:0] bx_q;
  logic [ByW-1:0] by_q;
  logic [15:0]    gen_lat_q, gen_count_q;
  logic           stop_seen_q, fbs_q, done_q;

  logic advance, px_last, bx_last, py_last, by_last, frame_last, run_end;
  logic [3:0] we_idx;

  assign advance    = (state_q == StScan) && !stall;
  assign px_last    = (px_q == 2'd2);
  assign bx_last    = (bx_q == BxW'(WIDTH_BLOCKS - 1));
  assign py_last    = (py_q == 2'd2);
  assign by_last    = (by_q == ByW'(HEIGHT_BLOCKS - 1));
  assign frame_last = px_last && bx_last && py_last && by_last;
  // A stop that arrives on the final pixel itself still ends a free run.
  assign run_end    = (gen_count_q + 16'd1 == gen_lat_q) ||
                      ((gen_lat_q == 16'd0) && (stop_seen_q || stop));

  // Block coordinate of the neighbour held by bank lane `lane` (row or column).
  // Only an edge pixel reaches into the adjacent block, through the opposite lane.
  function automatic int nb_coord(input int p, input int blk, input int lane);
    int off;
    off = 0;
    if (p == 0 && lane == 2) off = -1;
    else if (p == 2 && lane == 0) off = 1;
    return blk + off;
  endfunction

  // FSM, scan counters and registered run status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      px_q        <= '0;
      py_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      gen_lat_q   <= '0;
      gen_count_q <= '0;
      stop_seen_q <= 1'b0;
      fbs_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StScan;
            gen_lat_q   <= generations;
            gen_count_q <= '0;
            stop_seen_q <= 1'b0;
          end
        end
        StScan: begin
          if (stop) stop_seen_q <= 1'b1;
          if (!stall) begin
            px_q <= px_last ? 2'd0 : px_q + 2'd1;
            if (px_last) bx_q <= bx_last ? '0 : bx_q + 1'b1;
            if (px_last && bx_last) py_q <= py_last ? 2'd0 : py_q + 2'd1;
            if (px_last && bx_last && py_last) by_q <= by_last ? '0 : by_q + 1'b1;
            if (frame_last) begin
              fbs_q       <= ~fbs_q;
              gen_count_q <= gen_count_q + 16'd1;
              stop_seen_q <= 1'b0;
              if (run_end) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy                = (state_q == StScan);
  assign done                = done_q;
  assign frame_buffer_select = fbs_q;
  assign generation_count    = gen_count_q;

  // Centre pixel: bank chosen by position inside the block, address by block index
  always_comb begin
    we_idx       = {2'b00, py_q} * 4'd3 + {2'b00, px_q};
    write_enable = advance ? (9'd1 << we_idx) : 9'd0;
    write_addr   = ADDR_WIDTH'(int'(by_q) * int'(WIDTH_BLOCKS) + int'(bx_q));
  end

  for (genvar gk = 0; gk < 9; gk++) begin : g_bank
    localparam int Row = gk / 3;
    localparam int Col = gk % 3;

    int                    nx, ny;
    logic                  ok;
    logic                  bank_re;
    logic [ADDR_WIDTH-1:0] bank_ra;

    // Neighbour block for this bank, clipped or wrapped at the grid edge
    always_comb begin
      nx = nb_coord(int'(px_q), int'(bx_q), Col);
      ny = nb_coord(int'(py_q), int'(by_q), Row);
      ok = 1'b1;
      if (nx < 0) begin
        if (WRAP_MODE != 0) nx = int'(WIDTH_BLOCKS) - 1;
        else ok = 1'b0;
      end else if (nx >= int'(WIDTH_BLOCKS)) begin
        if (WRAP_MODE != 0) nx = 0;
        else ok = 1'b0;
      end
      if (ny < 0) begin
        if (WRAP_MODE != 0) ny = int'(HEIGHT_BLOCKS) - 1;
        else ok = 1'b0;
      end else if (ny >= int'(HEIGHT_BLOCKS)) begin
        if (WRAP_MODE != 0) ny = 0;
        else ok = 1'b0;
      end
      bank_re = advance && ok;
      // Addresses stay at 0 while idle so the read port is quiet between runs.
      bank_ra = (ok && state_q == StScan) ?
                ADDR_WIDTH'(ny * int'(WIDTH_BLOCKS) + nx) : '0;
    end

    assign read_enable[gk]                          = bank_re;
    assign read_addr[gk*ADDR_WIDTH +: ADDR_WIDTH]   = bank_ra;
  end

endmodule

// File: tb/tb_conway_scan_control.sv
// Bench for conway_scan_control on a 2x2-block grid, with dead-boundary and toroidal
// instances driven in parallel.
module tb_conway_scan_control;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int AW = 2;
  localparam int NPIX = 9 * W * H;

  logic        clk, resetn, start, stop, stall;
  logic [15:0] generations;

  logic        busy0, done0, fbs0, busy1, done1, fbs1;
  logic [8:0]  we0, re0, we1, re1;
  logic [AW-1:0] wa0, wa1;
  logic [9*AW-1:0] ra0, ra1;
  logic [15:0] gc0, gc1;

  conway_scan_control #(
    .WIDTH_BLOCKS (W), .HEIGHT_BLOCKS(H), .ADDR_WIDTH(AW), .WRAP_MODE(0)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start), .generations(generations), .stop(stop),
    .stall(stall), .busy(busy0), .done(done0), .write_enable(we0), .read_enable(re0),
    .write_addr(wa0), .read_addr(ra0), .frame_buffer_select(fbs0), .generation_count(gc0)
  );

  conway_scan_control #(
    .WIDTH_BLOCKS (W), .HEIGHT_BLOCKS(H), .ADDR_WIDTH(AW), .WRAP_MODE(1)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start), .generations(generations), .stop(stop),
    .stall(stall), .busy(busy1), .done(done1), .write_enable(we1), .read_enable(re1),
    .write_addr(wa1), .read_addr(ra1), .frame_buffer_select(fbs1), .generation_count(gc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state; position kept as a linear pixel index in scan order
  bit  m_scan, m_fbs, m_stop, m_done;
  int  m_n, m_gc, m_lat;
  int  m_px, m_bx, m_py, m_by;

  typedef struct {
    logic [8:0]      we, re0, re1;
    logic [AW-1:0]   wa;
    logic [9*AW-1:0] ra0, ra1;
    logic            busy, done, fbs;
    logic [15:0]     gc;
  } exp_t;

  exp_t sb[$];

  task automatic model_pos();
    m_px = m_n % 3;
    m_bx = (m_n / 3) % W;
    m_py = (m_n / (3 * W)) % 3;
    m_by = m_n / (9 * W);
  endtask

  task automatic model_reset();
    m_scan = 0; m_fbs = 0; m_stop = 0; m_done = 0;
    m_n = 0; m_gc = 0; m_lat = 0;
    model_pos();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit adv, in0;
    int r, c, dx, dy, sx, sy, nx, ny;
    adv   = m_scan && !stall;
    e.we  = adv ? (9'd1 << (m_py * 3 + m_px)) : 9'd0;
    e.wa  = AW'(m_by * W + m_bx);
    e.re0 = '0; e.re1 = '0; e.ra0 = '0; e.ra1 = '0;
    for (int k = 0; k < 9; k++) begin
      r  = k / 3;
      c  = k % 3;
      dx = ((c - m_px + 4) % 3) - 1;
      dy = ((r - m_py + 4) % 3) - 1;
      sx = m_px + dx;
      sy = m_py + dy;
      nx = m_bx + ((sx < 0) ? -1 : ((sx > 2) ? 1 : 0));
      ny = m_by + ((sy < 0) ? -1 : ((sy > 2) ? 1 : 0));
      in0 = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
      e.re0[k] = adv && in0;
      e.ra0[k*AW +: AW] = (m_scan && in0) ? AW'(ny * W + nx) : '0;
      nx = (nx + W) % W;
      ny = (ny + H) % H;
      e.re1[k] = adv;
      e.ra1[k*AW +: AW] = m_scan ? AW'(ny * W + nx) : '0;
    end
    e.busy = m_scan;
    e.done = m_done;
    e.fbs  = m_fbs;
    e.gc   = 16'(m_gc);
    return e;
  endfunction

  task automatic model_clock();
    m_done = 0;
    if (!m_scan) begin
      if (start) begin
        m_scan = 1; m_lat = int'(generations); m_gc = 0; m_stop = 0;
      end
    end else begin
      if (stop) m_stop = 1;
      if (!stall) begin
        if (m_n == NPIX - 1) begin
          m_n   = 0;
          m_fbs = !m_fbs;
          m_gc  = (m_gc + 1) & 16'hffff;
          if (m_gc == m_lat || (m_lat == 0 && m_stop)) begin
            m_scan = 0;
            m_done = 1;
          end
          m_stop = 0;
        end else begin
          m_n++;
        end
        model_pos();
      end
    end
  endtask

  // One clock: expectation queued with the stimulus, compared once the DUTs settle
  task automatic cyc();
    exp_t e;
    sb.push_back(model_out());
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("busy",     32'(busy0), 32'(e.busy));
      check("done",     32'(done0), 32'(e.done));
      check("fbs",      32'(fbs0),  32'(e.fbs));
      check("gen_cnt",  32'(gc0),   32'(e.gc));
      check("we",       32'(we0),   32'(e.we));
      check("wa",       32'(wa0),   32'(e.wa));
      check("re_dead",  32'(re0),   32'(e.re0));
      check("ra_dead",  32'(ra0),   32'(e.ra0));
      check("re_wrap",  32'(re1),   32'(e.re1));
      check("ra_wrap",  32'(ra1),   32'(e.ra1));
      check("wrap_we",  32'(we1),   32'(e.we));
      check("wrap_gc",  32'(gc1),   32'(e.gc));
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  // Runs the scan until busy drops, counting busy cycles
  task automatic run_frame(input int stall_from, input int stall_len, input int stop_at,
                           input bit chk_ends, output int nb);
    bit ended;
    nb = 0;
    ended = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!busy0) begin
        ended = 1;
        break;
      end
      stall = (nb >= stall_from) && (nb < stall_from + stall_len);
      stop  = (nb == stop_at);
      #1;
      if (stall) begin
        check("stall_we", 32'(we0), 32'h0);
        check("stall_re", 32'(re0), 32'h0);
        check("stall_wa", 32'(wa0), 32'd1);
      end
      if (chk_ends && nb == 0) begin
        check("first_we",      32'(we0), 32'h001);
        check("first_wa",      32'(wa0), 32'd0);
        check("first_re",      32'(re0), 32'b000011011);
        check("first_re_wrap", 32'(re1), 32'h1ff);
        check("wrap_bank2",    32'(ra1[5:4]),   32'd1);
        check("wrap_bank6",    32'(ra1[13:12]), 32'd2);
        check("wrap_bank8",    32'(ra1[17:16]), 32'd3);
      end
      if (chk_ends && nb == 35) begin
        check("last_we", 32'(we0), 32'h100);
        check("last_wa", 32'(wa0), 32'd3);
        check("last_re", 32'(re0), 32'b110110000);
      end
      nb++;
      cyc();
    end
    stall = 0;
    stop  = 0;
    if (!ended) check("run_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    bit          start;
    logic [15:0] gens;
    bit          stop;
    bit          stall;
    int          cycles;
    bit          exp_busy;
    logic [15:0] exp_gc;
    bit          exp_fbs;
  } seg_t;

  seg_t segs[7];
  int   nb;

  initial begin
    segs[0] = '{1, 16'd2, 0, 0, 1,  1, 16'd0, 0};
    segs[1] = '{0, 16'd0, 0, 0, 20, 1, 16'd0, 0};
    segs[2] = '{0, 16'd0, 0, 1, 4,  1, 16'd0, 0};
    segs[3] = '{1, 16'd9, 0, 0, 16, 1, 16'd1, 1};  // start ignored mid-run
    segs[4] = '{0, 16'd0, 0, 0, 35, 1, 16'd1, 1};
    segs[5] = '{0, 16'd0, 0, 0, 1,  0, 16'd2, 0};
    segs[6] = '{0, 16'd0, 1, 1, 3,  0, 16'd2, 0};

    resetn = 0; start = 0; stop = 0; stall = 0; generations = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1;

    // Idle after reset: everything quiet
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle_outs", {busy0, done0, fbs0, we0, re0, wa0}, 32'd0);
      check("idle_addr", {ra0, gc0[13:0]}, 32'd0);
      cyc();
    end

    // Table-driven segments
    for (int s = 0; s < 7; s++) begin
      start = segs[s].start; generations = segs[s].gens;
      stop = segs[s].stop;   stall = segs[s].stall;
      for (int i = 0; i < segs[s].cycles; i++) cyc();
      start = 0; stop = 0; stall = 0;
      #1;
      check($sformatf("seg%0d_busy", s), 32'(busy0), 32'(segs[s].exp_busy));
      check($sformatf("seg%0d_gc", s),   32'(gc0),   32'(segs[s].exp_gc));
      check($sformatf("seg%0d_fbs", s),  32'(fbs0),  32'(segs[s].exp_fbs));
    end

    // Single generation, dead boundary and wrap checks on first/last pixel
    generations = 16'd1; start = 1;
    cyc();
    start = 0;
    run_frame(1000, 0, -1, 1, nb);
    check("gen1_busy_cycles", 32'(nb), 32'd36);
    check("gen1_done", 32'(done0), 32'd1);
    check("gen1_fbs",  32'(fbs0),  32'd1);
    check("gen1_gc",   32'(gc0),   32'd1);
    cyc();

    // Five-cycle stall mid-frame stretches the frame to 41 cycles
    generations = 16'd1; start = 1;
    cyc();
    start = 0;
    run_frame(10, 5, -1, 0, nb);
    check("stall_busy_cycles", 32'(nb), 32'd41);
    check("stall_done", 32'(done0), 32'd1);
    check("stall_fbs",  32'(fbs0),  32'd0);
    cyc();

    // Free run stopped during the third frame
    generations = 16'd0; start = 1;
    cyc();
    start = 0;
    run_frame(1000, 0, 80, 0, nb);
    check("stop_busy_cycles", 32'(nb), 32'd108);
    check("stop_done", 32'(done0), 32'd1);
    check("stop_gc",   32'(gc0),   32'd3);
    check("stop_fbs",  32'(fbs0),  32'd1);
    cyc();

    // Free run interrupted by reset mid-frame
    generations = 16'd0; start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 82; i++) cyc();
    #2;
    resetn = 0;
    #1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_fbs",  32'(fbs0),  32'd0);
    check("rst_gc",   32'(gc0),   32'd0);
    check("rst_wa",   32'(wa0),   32'd0);
    check("rst_en",   {we0, re0, re1}, 32'd0);
    check("rst_ra",   {ra1, ra0[13:0]}, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 4; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
